// File: rtl/load_store_unit.sv
// Load/store unit: aligns core requests onto a DATA_W-wide bus, extends load data, bus timeout.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses return an error instead of aligning.
module load_store_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                we_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [OFF_W-1:0]    off_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                accept;
    logic [2:0]          low_mask;
    logic [7:0]          size_mask;
    logic [ADDR_W-1:0]   eff_addr;
    logic [OFF_W-1:0]    off;
    logic                size_ok;
    logic                req_err;

    assign accept = req_valid & req_ready;

    // Request decode: size masks, effective (size-aligned) address, error detection.
    always_comb begin
        case (req_size)
            2'b00:   begin low_mask = 3'b000; size_mask = 8'h01; end
            2'b01:   begin low_mask = 3'b001; size_mask = 8'h03; end
            2'b10:   begin low_mask = 3'b011; size_mask = 8'h0f; end
            default: begin low_mask = 3'b111; size_mask = 8'hff; end
        endcase
        size_ok  = !(req_size == 2'b11 && DATA_W == 32);
        eff_addr = req_addr & ~ADDR_W'(low_mask);
        off      = eff_addr[OFF_W-1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        req_err  = !size_ok || (|(req_addr[2:0] & low_mask));
`else
        req_err  = !size_ok;
`endif
    end

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_data;
    logic              sign_bit;
    int unsigned       nbits;

    // Load data: right-justify the addressed bytes, then sign/zero-extend above the access size.
    always_comb begin
        shifted = bus_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   begin nbits = 8;      sign_bit = shifted[7];        end
            2'b01:   begin nbits = 16;     sign_bit = shifted[15];       end
            2'b10:   begin nbits = 32;     sign_bit = shifted[31];       end
            default: begin nbits = DATA_W; sign_bit = shifted[DATA_W-1]; end
        endcase
        load_data = shifted;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (i >= nbits) load_data[i] = sign_bit & ~uns_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = req_err;
                    state_d = req_err ? StResp : StBus;
                end
            end
            StBus: begin
                // An ack on the last counted cycle takes priority over the timeout.
                if (bus_ack) begin
                    state_d = StResp;
                    rdata_d = we_q ? '0 : load_data;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = StResp;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                off_q   <= off;
                addr_q  <= {eff_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                be_q    <= BE_W'(size_mask) << off;
                wdata_q <= req_wdata << {off, 3'b000};
            end
        end
    end

    // Bus and response outputs are gated by state so they read zero outside their phase.
    always_comb begin
        req_ready  = (state_q == StIdle);
        bus_req    = (state_q == StBus);
        bus_we     = bus_req & we_q;
        bus_addr   = bus_req ? addr_q : '0;
        bus_be     = bus_req ? be_q : '0;
        bus_wdata  = bus_req ? wdata_q : '0;
        resp_valid = (state_q == StResp);
        resp_rdata = resp_valid ? rdata_q : '0;
        resp_err   = resp_valid & err_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (DATA_W=32, TIMEOUT=8) against an arithmetic model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    load_store_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Observations from the most recent transaction.
    logic        obs_accepted, obs_bus_seen, obs_we, obs_stable, obs_err, obs_ready_after;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic [3:0]  obs_be;
    int          obs_bus_cycles, obs_resp_cnt, obs_resp_cycle;

    // Reference model from the access rules, using plain integer arithmetic.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, output logic e_err,
                         output logic [31:0] e_addr, output logic [3:0] e_be,
                         output logic [31:0] e_wdata, output logic [31:0] e_rdata);
        longint unsigned nb, al, off, val, bits;
        nb    = 64'd1 << size;
        e_err = (size == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
        if (addr % nb != 0) e_err = 1'b1;
`endif
        al      = addr - (addr % nb);
        off     = al % 4;
        e_addr  = 32'(al - off);
        e_be    = 4'(((64'd1 << nb) - 1) << off);
        e_wdata = 32'(wdata * (64'd1 << (8 * off)));
        bits    = 8 * nb;
        val     = (64'(rdata) >> (8 * off)) % (64'd1 << bits);
        if (!uns && bits < 32 && val >= (64'd1 << (bits - 1)))
            val = val + (64'd1 << 32) - (64'd1 << bits);
        e_rdata = (we || e_err) ? 32'd0 : 32'(val);
    endtask

    // Drives one request; ack_wait = index of the bus cycle carrying bus_ack, -1 = never.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_wait, input logic [31:0] rdata);
        obs_bus_seen = 0; obs_stable = 1; obs_bus_cycles = 0; obs_resp_cnt = 0;
        obs_resp_cycle = -1; obs_ready_after = 0; obs_err = 0; obs_rdata = '0;
        obs_addr = '0; obs_be = '0; obs_wdata = '0; obs_we = 0;
        @(negedge clk);
        obs_accepted = req_ready;
        req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            req_valid = 0;
            bus_ack = 0;
            bus_rdata = $urandom;
            if (bus_req) begin
                if (!obs_bus_seen) begin
                    obs_addr = bus_addr; obs_be = bus_be; obs_wdata = bus_wdata; obs_we = bus_we;
                end else if (obs_addr !== bus_addr || obs_be !== bus_be ||
                             obs_wdata !== bus_wdata || obs_we !== bus_we) begin
                    obs_stable = 0;
                end
                obs_bus_seen = 1;
                obs_bus_cycles++;
                if (ack_wait >= 0 && obs_bus_cycles - 1 == ack_wait) begin
                    bus_ack = 1; bus_rdata = rdata;
                end
            end
            if (resp_valid) begin
                obs_resp_cnt++; obs_resp_cycle = n; obs_rdata = resp_rdata; obs_err = resp_err;
            end
            if (obs_resp_cnt > 0 && n == obs_resp_cycle + 1) begin
                obs_ready_after = req_ready;
                break;
            end
        end
        bus_ack = 0;
    endtask

    task automatic test_reset;
        #2 reset = 0;
        #1;
        n_checks++;
        if ({req_ready, bus_req, resp_valid, resp_err, bus_we} !== 5'b10000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b exp 10000", {req_ready, bus_req, resp_valid, resp_err, bus_we});
        end
        n_checks++;
        if ({bus_addr, bus_be, bus_wdata, resp_rdata} !== '0) begin
            n_errors++;
            $display("FAIL reset_data: addr %h be %b wdata %h rdata %h exp all 0",
                     bus_addr, bus_be, bus_wdata, resp_rdata);
        end
        repeat (3) @(negedge clk);
        reset = 1;
    endtask

    task automatic test_directed;
        // LB 0x103
        run_txn(0, 2'b00, 0, 32'h103, 32'h0, 0, 32'h80FF1234);
        n_checks++;
        if (obs_addr !== 32'h100 || obs_be !== 4'b1000) begin
            n_errors++; $display("FAIL lb_bus: addr %h be %b exp 100 1000", obs_addr, obs_be);
        end
        n_checks++;
        if (obs_rdata !== 32'hFFFFFF80 || obs_err !== 0) begin
            n_errors++; $display("FAIL lb_data: got %h err %b exp ffffff80 0", obs_rdata, obs_err);
        end
        n_checks++;
        if (obs_resp_cycle !== 2) begin
            n_errors++; $display("FAIL lb_latency: got %0d exp 2", obs_resp_cycle);
        end
        // LHU 0x102
        run_txn(0, 2'b01, 1, 32'h102, 32'h0, 0, 32'h80010000);
        n_checks++;
        if (obs_be !== 4'b1100 || obs_rdata !== 32'h00008001) begin
            n_errors++; $display("FAIL lhu: be %b rdata %h exp 1100 00008001", obs_be, obs_rdata);
        end
        // SH 0x102
        run_txn(1, 2'b01, 0, 32'h102, 32'h0000BEEF, 1, 32'hDEADBEEF);
        n_checks++;
        if (obs_we !== 1 || obs_be !== 4'b1100 || obs_wdata[31:16] !== 16'hBEEF) begin
            n_errors++;
            $display("FAIL sh_bus: we %b be %b wdata %h exp 1 1100 beef....", obs_we, obs_be, obs_wdata);
        end
        n_checks++;
        if (obs_rdata !== 0 || obs_err !== 0 || obs_resp_cnt !== 1) begin
            n_errors++;
            $display("FAIL sh_resp: rdata %h err %b cnt %0d exp 0 0 1", obs_rdata, obs_err, obs_resp_cnt);
        end
        // LW 0x101
        run_txn(0, 2'b10, 0, 32'h101, 32'h0, 0, 32'h12345678);
`ifdef LSU_MISALIGN_TRAP_EN
        n_checks++;
        if (obs_bus_seen !== 0 || obs_err !== 1 || obs_resp_cycle !== 1) begin
            n_errors++;
            $display("FAIL lw_misalign: bus %b err %b cyc %0d exp 0 1 1", obs_bus_seen, obs_err, obs_resp_cycle);
        end
`else
        n_checks++;
        if (obs_addr !== 32'h100 || obs_be !== 4'b1111 || obs_err !== 0 || obs_rdata !== 32'h12345678) begin
            n_errors++;
            $display("FAIL lw_align: addr %h be %b err %b rdata %h exp 100 1111 0 12345678",
                     obs_addr, obs_be, obs_err, obs_rdata);
        end
`endif
        // Doubleword on a 32-bit bus is illegal
        run_txn(0, 2'b11, 0, 32'h200, 32'h0, 0, 32'h0);
        n_checks++;
        if (obs_bus_seen !== 0 || obs_err !== 1 || obs_resp_cycle !== 1 || obs_ready_after !== 1) begin
            n_errors++;
            $display("FAIL ld_illegal: bus %b err %b cyc %0d rdy %b exp 0 1 1 1",
                     obs_bus_seen, obs_err, obs_resp_cycle, obs_ready_after);
        end
    endtask

    task automatic test_random;
        logic        we, uns, e_err;
        logic [1:0]  size;
        logic [31:0] addr, wdata, rdata, e_addr, e_wdata, e_rdata, m;
        logic [3:0]  e_be;
        int          aw, r;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom); uns = 1'($urandom);
            r = $urandom_range(0, 7);
            size = (r == 7) ? 2'd3 : 2'(r % 3);
            addr = $urandom; wdata = $urandom; rdata = $urandom;
            aw = $urandom_range(0, 3);
            model(we, size, uns, addr, wdata, rdata, e_err, e_addr, e_be, e_wdata, e_rdata);
            run_txn(we, size, uns, addr, wdata, aw, rdata);
            n_checks++;
            if (obs_accepted !== 1 || obs_resp_cnt !== 1 || obs_ready_after !== 1) begin
                n_errors++;
                $display("FAIL rnd%0d handshake: acc %b resp %0d rdy %b exp 1 1 1",
                         i, obs_accepted, obs_resp_cnt, obs_ready_after);
            end
            n_checks++;
            if (obs_err !== e_err || obs_rdata !== e_rdata) begin
                n_errors++;
                $display("FAIL rnd%0d resp: err %b rdata %h exp %b %h", i, obs_err, obs_rdata, e_err, e_rdata);
            end
            n_checks++;
            if (obs_resp_cycle !== (e_err ? 1 : aw + 2) || obs_bus_cycles !== (e_err ? 0 : aw + 1)) begin
                n_errors++;
                $display("FAIL rnd%0d timing: resp %0d bus %0d exp %0d %0d", i, obs_resp_cycle,
                         obs_bus_cycles, e_err ? 1 : aw + 2, e_err ? 0 : aw + 1);
            end
            if (!e_err) begin
                m = {{8{e_be[3]}}, {8{e_be[2]}}, {8{e_be[1]}}, {8{e_be[0]}}};
                n_checks++;
                if (obs_addr !== e_addr || obs_be !== e_be || obs_we !== we || obs_stable !== 1) begin
                    n_errors++;
                    $display("FAIL rnd%0d bus: addr %h be %b we %b stab %b exp %h %b %b 1",
                             i, obs_addr, obs_be, obs_we, obs_stable, e_addr, e_be, we);
                end
                n_checks++;
                if (we && (obs_wdata & m) !== (e_wdata & m)) begin
                    n_errors++;
                    $display("FAIL rnd%0d wdata: got %h exp %h mask %h", i, obs_wdata, e_wdata, m);
                end
            end
        end
    endtask

    task automatic test_timeout;
        run_txn(0, 2'b10, 0, 32'h40, 32'h0, -1, 32'h0);
        n_checks++;
        if (obs_bus_cycles !== 8 || obs_stable !== 1) begin
            n_errors++; $display("FAIL timeout_busreq: cycles %0d stab %b exp 8 1", obs_bus_cycles, obs_stable);
        end
        n_checks++;
        if (obs_err !== 1 || obs_resp_cycle !== 9 || obs_resp_cnt !== 1 || obs_ready_after !== 1) begin
            n_errors++;
            $display("FAIL timeout_resp: err %b cyc %0d cnt %0d rdy %b exp 1 9 1 1",
                     obs_err, obs_resp_cycle, obs_resp_cnt, obs_ready_after);
        end
        // Ack on the eighth (last counted) cycle wins over the timeout
        run_txn(0, 2'b00, 1, 32'h41, 32'h0, 7, 32'h0000A500);
        n_checks++;
        if (obs_err !== 0 || obs_rdata !== 32'h000000A5 || obs_resp_cycle !== 9) begin
            n_errors++;
            $display("FAIL ack_last: err %b rdata %h cyc %0d exp 0 000000a5 9", obs_err, obs_rdata, obs_resp_cycle);
        end
    endtask

    task automatic test_ack_outside;
        int bad;
        bad = 0;
        @(negedge clk);
        bus_ack = 1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (resp_valid !== 0 || bus_req !== 0 || req_ready !== 1) bad++;
        end
        bus_ack = 0;
        n_checks++;
        if (bad !== 0) begin
            n_errors++; $display("FAIL ack_idle: %0d bad cycles exp 0", bad);
        end
        run_txn(0, 2'b01, 0, 32'h6, 32'h0, 2, 32'h8000_0000);
        n_checks++;
        if (obs_rdata !== 32'hFFFF8000 || obs_err !== 0) begin
            n_errors++; $display("FAIL after_ack_idle: rdata %h err %b exp ffff8000 0", obs_rdata, obs_err);
        end
    endtask

    task automatic test_reset_inflight;
        int bad;
        bad = 0;
        @(negedge clk);
        req_valid = 1; req_we = 1; req_size = 2'b10; req_addr = 32'h80; req_wdata = 32'h1;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        n_checks++;
        if (bus_req !== 1) begin
            n_errors++; $display("FAIL inflight_busreq: got %b exp 1", bus_req);
        end
        #2 reset = 0;
        #1;
        n_checks++;
        if (bus_req !== 0 || req_ready !== 1 || bus_be !== 0 || bus_addr !== 0 || bus_we !== 0) begin
            n_errors++;
            $display("FAIL async_reset: req %b rdy %b be %b addr %h we %b exp 0 1 0 0 0",
                     bus_req, req_ready, bus_be, bus_addr, bus_we);
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (resp_valid !== 0 || bus_req !== 0) bad++;
        end
        reset = 1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (resp_valid !== 0 || req_ready !== 1) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_errors++; $display("FAIL reset_abandon: %0d bad cycles exp 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_timeout();
        test_ack_outside();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum bus wait cycles before error; minimum 1.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  core request present.
REQ-007 SHALL have port req_ready  output  1  unit can accept a request.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 double.
REQ-010 SHALL have port req_unsigned  input  1  zero-extend load when 1, sign-extend when 0.
REQ-011 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-012 SHALL have port req_wdata  input  DATA_W  store data, right-justified.
REQ-013 SHALL have port resp_valid  output  1  one-cycle response pulse.
REQ-014 SHALL have port resp_rdata  output  DATA_W  extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err  output  1  error flag, qualified by resp_valid.
REQ-016 SHALL have ports bus_req (output, 1), bus_we (output, 1), bus_addr (output, ADDR_W), bus_be (output, DATA_W/8), bus_wdata (output, DATA_W), bus_ack (input, 1), bus_rdata (input, DATA_W).

Function
REQ-017 SHALL implement FSM states IDLE, BUS, RESP; transitions: IDLE->BUS on accept of a legal request, IDLE->RESP on accept of an erroring request, BUS->RESP on bus_ack or timeout, RESP->IDLE unconditionally.
REQ-018 SHALL drive req_ready=1 only in IDLE; accept = req_valid & req_ready; request fields register on accept.
REQ-019 SHALL drive bus_req=1 throughout BUS, starting the cycle after accept; bus_we/bus_addr/bus_be/bus_wdata stable while bus_req=1.
REQ-020 SHALL drive bus_addr = request address with low log2(DATA_W/8) bits cleared.
REQ-021 SHALL drive bus_be = size mask (1, 2, 4 or 8 ones) shifted left by byte offset, for loads and stores.
REQ-022 SHALL drive bus_wdata = req_wdata shifted left by 8 x byte offset; bytes outside bus_be are don't-care.
REQ-023 SHALL sample bus_rdata on the bus_ack cycle, shift right by 8 x offset, and sign- or zero-extend from the access size to DATA_W.
REQ-024 SHALL ignore req_unsigned when access size equals DATA_W.
REQ-025 SHALL pulse resp_valid for exactly one cycle in RESP, one cycle after bus_ack or after error detection; resp_valid has no backpressure.
REQ-026 SHALL count BUS cycles without bus_ack; when TIMEOUT cycles elapse, drop bus_req, enter RESP with resp_err=1; bus_ack on the final counted cycle SHALL win over timeout.
REQ-027 SHALL treat req_size=11 with DATA_W=32 as illegal: resp_err=1, no bus transaction.
REQ-028 SHALL ignore bus_ack outside BUS.
REQ-029 SHALL have minimum latency accept -> resp_valid of 3 cycles with zero-wait bus_ack, and 2 cycles for erroring requests.

Reset
REQ-030 SHALL, while reset=0, force FSM to IDLE, the timeout counter to 0, req_ready=1, and resp_valid, resp_rdata, resp_err, bus_req, bus_we, bus_addr, bus_be and bus_wdata to 0, asynchronously.
REQ-031 SHALL abandon an in-flight transaction on reset without producing a response.

Configuration
REQ-032 SHALL provide macro LSU_MISALIGN_TRAP_EN; when defined, an access whose address is not a multiple of its size SHALL produce resp_err=1 with no bus transaction.
REQ-033 SHALL, without LSU_MISALIGN_TRAP_EN, clear the address bits below the access size and perform the access normally with resp_err=0.

Verification
REQ-034 SHALL cover: LB, addr 0x103, bus_rdata 0x80FF1234 -> bus_addr 0x100, bus_be 1000, resp_rdata 0xFFFFFF80.
REQ-035 SHALL cover: LHU, addr 0x102, bus_rdata 0x80010000 -> bus_be 1100, resp_rdata 0x00008001.
REQ-036 SHALL cover: SH, addr 0x102, wdata 0x0000BEEF -> bus_we 1, bus_be 1100, bus_wdata[31:16] 0xBEEF, resp_rdata 0, resp_err 0.
REQ-037 SHALL cover: LW, addr 0x101 -> with macro: bus_req never 1, resp_err 1 two cycles after accept; without macro: bus_addr 0x100, bus_be 1111, resp_err 0.
REQ-038 SHALL cover: TIMEOUT=8, bus_ack held 0 -> bus_req high 8 cycles then 0, resp_valid=1 with resp_err=1, then req_ready 1.
REQ-039 SHALL cover: reset driven 0 while bus_req=1 -> bus_req 0 immediately, no resp_valid, req_ready 1 after reset returns 1.
